// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory bus between mem_stage and the data memory
interface mem_stage_if;
    logic        MEM_dmem_req_out;
    logic        MEM_dmem_we_out;
    logic [31:0] MEM_dmem_addr_out;
    logic [31:0] MEM_dmem_wdata_out;
    logic [3:0]  MEM_dmem_be_out;
    logic        MEM_dmem_ack_in;
    logic [31:0] MEM_dmem_rdata_in;

    modport master (
        output MEM_dmem_req_out, MEM_dmem_we_out, MEM_dmem_addr_out,
               MEM_dmem_wdata_out, MEM_dmem_be_out,
        input  MEM_dmem_ack_in, MEM_dmem_rdata_in
    );

    modport slave (
        input  MEM_dmem_req_out, MEM_dmem_we_out, MEM_dmem_addr_out,
               MEM_dmem_wdata_out, MEM_dmem_be_out,
        output MEM_dmem_ack_in, MEM_dmem_rdata_in
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: big-endian load/store with alignment check and ack timeout
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_valid_in,
    input  logic [31:0] MEM_res_in,
    input  logic [31:0] MEM_store_data_in,
    input  logic [1:0]  MEM_op_in,
    input  logic [5:0]  MEM_op3_in,
    input  logic [4:0]  MEM_rd_in,
    input  logic        MEM_regwrite_in,
    output logic        MEM_stall_out,
    mem_stage_if.master dmem,
    output logic        MEM_wb_valid_out,
    output logic        MEM_wb_en_out,
    output logic [4:0]  MEM_wb_rd_out,
    output logic [31:0] MEM_wb_data_out,
    output logic        MEM_align_err_out,
    output logic        MEM_bus_err_out
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic { IDLE, ACCESS } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    sz_q;
    logic [1:0]    off_q;
    logic          sgn_q;
    logic          store_q;
    logic          regw_q;

    logic          is_mem;
    logic          misaligned;
    logic [3:0]    be_n;
    logic [31:0]   wdata_n;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   load_data;

    // op3[1:0] is the access size (00 word, 01 byte, 10 half), op3[2] marks a store, op3[3] a signed load
    always_comb begin
        is_mem     = 1'b0;
        misaligned = 1'b0;
        be_n       = 4'b0000;
        wdata_n    = 32'd0;
        if (MEM_op_in == 2'b11) begin
            case (MEM_op3_in)
                6'b000000, 6'b000001, 6'b000010, 6'b000100,
                6'b000101, 6'b000110, 6'b001001, 6'b001010: is_mem = 1'b1;
                default: is_mem = 1'b0;
            endcase
        end
        case (MEM_op3_in[1:0])
            2'b00: begin
                misaligned = |MEM_res_in[1:0];
                be_n       = 4'b1111;
                wdata_n    = MEM_store_data_in;
            end
            2'b10: begin
                misaligned = MEM_res_in[0];
                be_n       = MEM_res_in[1] ? 4'b0011 : 4'b1100;
                wdata_n    = {2{MEM_store_data_in[15:0]}};
            end
            default: begin
                misaligned = 1'b0;
                be_n       = 4'b1000 >> MEM_res_in[1:0];
                wdata_n    = {4{MEM_store_data_in[7:0]}};
            end
        endcase
    end

    // Byte offset 0 lives in the most significant lane
    always_comb begin
        lane_b = 8'(dmem.MEM_dmem_rdata_in >> {~off_q, 3'b000});
        lane_h = off_q[1] ? dmem.MEM_dmem_rdata_in[15:0] : dmem.MEM_dmem_rdata_in[31:16];
        case (sz_q)
            2'b00:   load_data = dmem.MEM_dmem_rdata_in;
            2'b10:   load_data = {{16{sgn_q & lane_h[15]}}, lane_h};
            default: load_data = {{24{sgn_q & lane_b[7]}}, lane_b};
        endcase
    end

    assign MEM_stall_out = (state == ACCESS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= IDLE;
            cnt                     <= '0;
            sz_q                    <= 2'b00;
            off_q                   <= 2'b00;
            sgn_q                   <= 1'b0;
            store_q                 <= 1'b0;
            regw_q                  <= 1'b0;
            dmem.MEM_dmem_req_out   <= 1'b0;
            dmem.MEM_dmem_we_out    <= 1'b0;
            dmem.MEM_dmem_addr_out  <= 32'd0;
            dmem.MEM_dmem_wdata_out <= 32'd0;
            dmem.MEM_dmem_be_out    <= 4'b0000;
            MEM_wb_valid_out        <= 1'b0;
            MEM_wb_en_out           <= 1'b0;
            MEM_wb_rd_out           <= 5'd0;
            MEM_wb_data_out         <= 32'd0;
            MEM_align_err_out       <= 1'b0;
            MEM_bus_err_out         <= 1'b0;
        end else begin
            MEM_wb_valid_out  <= 1'b0;
            MEM_wb_en_out     <= 1'b0;
            MEM_align_err_out <= 1'b0;
            MEM_bus_err_out   <= 1'b0;
            case (state)
                IDLE: begin
                    if (MEM_valid_in) begin
                        MEM_wb_rd_out <= MEM_rd_in;
                        if (!is_mem) begin
                            MEM_wb_valid_out <= 1'b1;
                            MEM_wb_en_out    <= MEM_regwrite_in && (MEM_rd_in != 5'd0)
                                                && (MEM_op_in != 2'b11);
                            MEM_wb_data_out  <= MEM_res_in;
                        end else if (misaligned) begin
                            MEM_wb_valid_out  <= 1'b1;
                            MEM_wb_data_out   <= 32'd0;
                            MEM_align_err_out <= 1'b1;
                        end else begin
                            state                   <= ACCESS;
                            cnt                     <= '0;
                            sz_q                    <= MEM_op3_in[1:0];
                            off_q                   <= MEM_res_in[1:0];
                            sgn_q                   <= MEM_op3_in[3];
                            store_q                 <= MEM_op3_in[2];
                            regw_q                  <= MEM_regwrite_in;
                            dmem.MEM_dmem_req_out   <= 1'b1;
                            dmem.MEM_dmem_we_out    <= MEM_op3_in[2];
                            dmem.MEM_dmem_addr_out  <= {MEM_res_in[31:2], 2'b00};
                            dmem.MEM_dmem_wdata_out <= MEM_op3_in[2] ? wdata_n : 32'd0;
                            dmem.MEM_dmem_be_out    <= be_n;
                        end
                    end
                end
                ACCESS: begin
                    if (dmem.MEM_dmem_ack_in || cnt == CNT_LAST) begin
                        state                   <= IDLE;
                        dmem.MEM_dmem_req_out   <= 1'b0;
                        dmem.MEM_dmem_we_out    <= 1'b0;
                        dmem.MEM_dmem_addr_out  <= 32'd0;
                        dmem.MEM_dmem_wdata_out <= 32'd0;
                        dmem.MEM_dmem_be_out    <= 4'b0000;
                        MEM_wb_valid_out        <= 1'b1;
                        // ack wins over a timeout landing in the same cycle
                        if (dmem.MEM_dmem_ack_in) begin
                            MEM_wb_en_out   <= !store_q && regw_q && (MEM_wb_rd_out != 5'd0);
                            MEM_wb_data_out <= store_q ? 32'd0 : load_data;
                        end else begin
                            MEM_wb_data_out <= 32'd0;
                            MEM_bus_err_out <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
